// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
// Shared definitions for the mem_responder slice: FSM state encoding,
// response-latency limits and the stall LFSR seed, taps and step function.
// No ports (package).

package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    IRESP = 2'd2,
    DRESP = 2'd3
  } state_t;

  localparam int RESP_LAT_MIN = 1;
  localparam int RESP_LAT_MAX = 15;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (right-shifting).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    lfsr_step = {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/strb_ram.sv
// strb_ram
// Single-port word RAM with byte write strobes, synchronous write and
// combinational read. Contents are never cleared.
// Ports:
//   clk    in  clock
//   we     in  write enable (write happens on the rising edge)
//   addr   in  word address, shared by read and write
//   wdata  in  write word
//   strb   in  byte strobes, bit b enables byte b
//   rdata  out word at addr (combinational)

module strb_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        strb,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Memory model answering instruction fetches and data loads/stores from one
// internal byte-strobed RAM. Loads and fetches are answered after RESP_LAT
// cycles through valid/ready response handshakes; stores complete at the
// accepting edge with no response. Data requests win over fetches.
// Optional build macro MEM_RAND_STALL_EN: adds a 0..3 cycle random stall
// (from a 16-bit LFSR) every time the FSM returns to IDLE.
// Ports:
//   clk, rst                            clock, synchronous active-high reset
//   inst_addr, inst_req_valid/ready     fetch request
//   instruction, inst_valid/ready       fetch response
//   mem_addr, mem_write, write_data,
//   write_strb, mem_read, mem_req_ready data request (loads and stores)
//   read_data, read_data_valid/ready    load response

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int RESP_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr,
  input  logic        inst_req_valid,
  output logic        inst_req_ready,
  output logic [31:0] instruction,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic [31:0] mem_addr,
  input  logic        mem_write,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_strb,
  input  logic        mem_read,
  output logic        mem_req_ready,
  output logic [31:0] read_data,
  output logic        read_data_valid,
  input  logic        read_data_ready
);

  localparam int LAT_CLAMPED = (RESP_LAT < RESP_LAT_MIN) ? RESP_LAT_MIN :
                               (RESP_LAT > RESP_LAT_MAX) ? RESP_LAT_MAX : RESP_LAT;
  localparam logic [3:0] LAT_M1 = 4'(LAT_CLAMPED - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        is_data;
  logic [31:0] resp_data;
  logic [31:0] ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic        idle_ok, data_req;
  logic        store_acc, load_acc, fetch_acc;

  // Only the word-index bits of each address reach the RAM; the rest wrap away.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr[31:ADDR_W+2], inst_addr[1:0],
                              mem_addr[31:ADDR_W+2], mem_addr[1:0]};

`ifdef MEM_RAND_STALL_EN
  logic [15:0] lfsr, lfsr_nxt;
  logic [1:0]  stall;

  assign lfsr_nxt = lfsr_step(lfsr);

  // A fresh stall count is drawn each time a response completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr  <= LFSR_SEED;
      stall <= 2'd0;
    end else if (state != IDLE && state_nxt == IDLE) begin
      lfsr  <= lfsr_nxt;
      stall <= lfsr_nxt[1:0];
    end else if (state == IDLE && stall != 2'd0) begin
      stall <= stall - 2'd1;
    end
  end
`else
  logic [1:0] stall;
  assign stall = 2'd0;
`endif

  // Readies are forced low during reset so nothing is accepted that cycle.
  assign data_req       = mem_read | mem_write;
  assign idle_ok        = !rst && state == IDLE && stall == 2'd0;
  assign mem_req_ready  = idle_ok;
  assign inst_req_ready = idle_ok && !data_req;

  // A read together with a write is a store only.
  assign store_acc = mem_req_ready && mem_write;
  assign load_acc  = mem_req_ready && mem_read && !mem_write;
  assign fetch_acc = inst_req_ready && inst_req_valid;

  assign ram_addr = data_req ? mem_addr[ADDR_W+1:2] : inst_addr[ADDR_W+1:2];

  strb_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (store_acc),
    .addr  (ram_addr),
    .wdata (write_data),
    .strb  (write_strb),
    .rdata (ram_rdata)
  );

  // State register, latency counter and captured response word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      is_data   <= 1'b0;
      resp_data <= 32'd0;
    end else begin
      state <= state_nxt;
      if (fetch_acc || load_acc) begin
        cnt       <= LAT_M1;
        is_data   <= load_acc;
        resp_data <= ram_rdata;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Next state. WAIT leaves on the cycle its counter decrements to zero,
  // which makes accept-to-valid exactly RESP_LAT cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load_acc || fetch_acc) begin
          if (LAT_M1 == 4'd0) state_nxt = load_acc ? DRESP : IRESP;
          else                state_nxt = WAIT;
        end
      end
      WAIT:    if (cnt == 4'd1) state_nxt = is_data ? DRESP : IRESP;
      IRESP:   if (inst_ready) state_nxt = IDLE;
      DRESP:   if (read_data_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign inst_valid      = state == IRESP;
  assign read_data_valid = state == DRESP;
  assign instruction     = (state == IRESP) ? resp_data : 32'd0;
  assign read_data       = (state == DRESP) ? resp_data : 32'd0;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Randomized and directed bench for mem_responder (ADDR_W=10, RESP_LAT=3)
// checked against an array model of the RAM with byte-mask merging.

module tb_mem_responder;

  localparam int ADDR_W = 10;
  localparam int LAT    = 3;
  localparam int WORDS  = 1 << ADDR_W;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic        inst_req_valid, inst_req_ready;
  logic [31:0] instruction;
  logic        inst_valid, inst_ready;
  logic [31:0] mem_addr, write_data;
  logic        mem_write, mem_read, mem_req_ready;
  logic [3:0]  write_strb;
  logic [31:0] read_data;
  logic        read_data_valid, read_data_ready;

  int total  = 0;
  int passed = 0;

  logic [31:0] model_mem [WORDS];

  mem_responder #(.ADDR_W(ADDR_W), .RESP_LAT(LAT)) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_addr       (inst_addr),
    .inst_req_valid  (inst_req_valid),
    .inst_req_ready  (inst_req_ready),
    .instruction     (instruction),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .mem_addr        (mem_addr),
    .mem_write       (mem_write),
    .write_data      (write_data),
    .write_strb      (write_strb),
    .mem_read        (mem_read),
    .mem_req_ready   (mem_req_ready),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .read_data_ready (read_data_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr / 4) % WORDS);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    logic [31:0] mask;
    mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    return (old & ~mask) | (data & mask);
  endfunction

  task automatic waitReady(input string tag, input bit inst);
    int n = 0;
    while ((inst ? !inst_req_ready : !mem_req_ready) && n < 20) begin
      tick();
      n++;
    end
    if (inst ? !inst_req_ready : !mem_req_ready) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic applyStore(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    mem_addr = addr; write_data = data; write_strb = strb; mem_write = 1'b1;
    #1;
    waitReady("store", 1'b0);
    tick();
    mem_write = 1'b0;
    model_mem[word_of(addr)] = merge(model_mem[word_of(addr)], data, strb);
    #1;
    checkOutput("store_no_resp", {30'd0, read_data_valid, inst_valid}, 32'd0);
  endtask

  task automatic applyLoad(input logic [31:0] addr, input int hold, input string tag,
                           output logic [31:0] got);
    logic [31:0] exp;
    int lat;
    mem_addr = addr; mem_read = 1'b1; read_data_ready = 1'b0;
    #1;
    waitReady(tag, 1'b0);
    exp = model_mem[word_of(addr)];
    tick();
    mem_read = 1'b0;
    lat = 1;
    while (!read_data_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_lat"}, lat, LAT);
    got = read_data;
    checkOutput({tag, "_data"}, read_data, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput({tag, "_hold_valid"}, {31'd0, read_data_valid}, 32'd1);
      checkOutput({tag, "_hold_data"}, read_data, exp);
    end
    read_data_ready = 1'b1;
    tick();
    read_data_ready = 1'b0;
    checkOutput({tag, "_idle"}, {30'd0, read_data_valid, mem_req_ready}, 32'd1);
    checkOutput({tag, "_zero"}, read_data, 32'd0);
  endtask

  task automatic applyFetch(input logic [31:0] addr, input int hold, input string tag,
                            output logic [31:0] got);
    logic [31:0] exp;
    int lat;
    inst_addr = addr; inst_req_valid = 1'b1; inst_ready = 1'b0;
    #1;
    waitReady(tag, 1'b1);
    exp = model_mem[word_of(addr)];
    tick();
    inst_req_valid = 1'b0;
    lat = 1;
    while (!inst_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_lat"}, lat, LAT);
    got = instruction;
    checkOutput({tag, "_data"}, instruction, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      checkOutput({tag, "_hold_data"}, instruction, exp);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    checkOutput({tag, "_idle"}, {30'd0, inst_valid, inst_req_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] got, addr;
    int n;
    bit seen;
    rst = 1'b1;
    inst_addr = '0; inst_req_valid = 0; inst_ready = 0;
    mem_addr = '0; mem_write = 0; write_data = '0; write_strb = '0;
    mem_read = 0; read_data_ready = 0;
    tick();
    tick();
    checkOutput("rst_ready", {30'd0, inst_req_ready, mem_req_ready}, 32'd0);
    checkOutput("rst_valid", {30'd0, inst_valid, read_data_valid}, 32'd0);
    checkOutput("rst_data", instruction | read_data, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", {30'd0, inst_req_ready, mem_req_ready}, 32'd3);

    // Seed the low 64 words so every later read has a known value.
    for (int i = 0; i < 64; i++) applyStore(32'(i * 4), $urandom, 4'hF);

    // Full-word store then load.
    applyStore(32'h10, 32'h12345678, 4'hF);
    applyLoad(32'h10, 0, "full_word", got);
    checkOutput("full_word_value", got, 32'h12345678);

    // Single-byte strobe into a zero word.
    applyStore(32'h20, 32'h0, 4'hF);
    applyStore(32'h20, 32'hAABBCCDD, 4'b0100);
    applyLoad(32'h20, 0, "byte_strb", got);
    checkOutput("byte_strb_value", got, 32'h00BB0000);

    // Read and write together behave as a store only.
    mem_addr = 32'h24; write_data = 32'hFEEDBEEF; write_strb = 4'hF;
    mem_write = 1'b1; mem_read = 1'b1;
    #1;
    tick();
    mem_write = 1'b0; mem_read = 1'b0;
    model_mem[9] = 32'hFEEDBEEF;
    #1;
    checkOutput("rw_no_resp", {30'd0, read_data_valid, mem_req_ready}, 32'd1);
    applyLoad(32'h24, 0, "rw_store", got);

    // Simultaneous fetch and load: the load goes first.
    mem_addr = 32'h10; mem_read = 1'b1; read_data_ready = 1'b1;
    inst_addr = 32'h0; inst_req_valid = 1'b1; inst_ready = 1'b1;
    #1;
    checkOutput("conc_ready", {30'd0, inst_req_ready, mem_req_ready}, 32'd1);
    tick();
    mem_read = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!read_data_valid && n < 20) begin
      if (inst_req_ready) seen = 1'b1;
      tick();
      n++;
    end
    checkOutput("conc_inst_blocked", {31'd0, seen}, 32'd0);
    checkOutput("conc_load_data", read_data, 32'h12345678);
    checkOutput("conc_dresp_iready", {31'd0, inst_req_ready}, 32'd0);
    tick();
    read_data_ready = 1'b0;
    checkOutput("conc_after_hs", {31'd0, inst_req_ready}, 32'd1);
    tick();
    inst_req_valid = 1'b0;
    n = 1;
    while (!inst_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("conc_fetch_lat", n, LAT);
    checkOutput("conc_fetch_data", instruction, model_mem[0]);
    tick();
    inst_ready = 1'b0;

    // Back-pressured load response.
    applyLoad(32'h10, 5, "backpressure", got);

    // Reset while waiting for a response.
    applyStore(32'h40, 32'h5A5AA5A5, 4'hF);
    mem_addr = 32'h40; mem_read = 1'b1;
    #1;
    tick();
    mem_read = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_wait_ready", {30'd0, inst_req_ready, mem_req_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rst_wait_after", {30'd0, inst_req_ready, mem_req_ready}, 32'd3);
    seen = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      if (read_data_valid || inst_valid) seen = 1'b1;
      tick();
    end
    checkOutput("rst_wait_no_resp", {31'd0, seen}, 32'd0);
    applyLoad(32'h40, 0, "rst_keep", got);
    checkOutput("rst_keep_value", got, 32'h5A5AA5A5);

    // Fetch beyond the RAM wraps to word 0.
    applyStore(32'h0, 32'hCAFEF00D, 4'hF);
    applyFetch(32'h1000, 0, "wrap_fetch", got);
    checkOutput("wrap_fetch_value", got, 32'hCAFEF00D);

    // Random traffic over the seeded words with random high address bits.
    for (int i = 0; i < 60; i++) begin
      addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63) * 4);
      case ($urandom_range(0, 2))
        0: applyStore(addr | 32'($urandom_range(0, 3)), $urandom, 4'($urandom_range(0, 15)));
        1: applyLoad(addr | 32'($urandom_range(0, 3)), $urandom_range(0, 3), "rand_load", got);
        default: applyFetch(addr, $urandom_range(0, 3), "rand_fetch", got);
      endcase
    end

    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
